// File: rtl/input_cond_pkg.sv
// Shared defaults and helpers for the input conditioner.
// The channel-vector type (logic [N_CH-1:0]) depends on N_CH, so each user
// declares it locally. This package holds only the default constants and the
// counter-width helper.
package input_cond_pkg;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_DEBOUNCE_TICKS = 4;
    localparam int DEF_REPEAT_DELAY   = 50;
    localparam int DEF_REPEAT_RATE    = 10;

    // Returns the width of a counter that can hold the values 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/input_cond_chan.sv
// Conditions one asynchronous pin input.
// The pin is synchronised and polarity-corrected, then debounced on tick
// strobes. The block produces a clean active-high level plus one-clock
// press/release pulses.
// Optional feature: define INPUT_COND_REPEAT_EN to get auto-repeat press pulses
// while the input is held. Without the macro, no repeat logic exists.
// Ports:
//   clk           in  system clock
//   rst           in  synchronous reset, active-high
//   tick          in  debounce sample strobe, one clk wide
//   raw           in  asynchronous pin
//   level         out debounced level (1 = pressed)
//   press_pulse   out one-clk pulse on accepted press (and on repeats)
//   release_pulse out one-clk pulse on accepted release
module input_cond_chan
    import input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter logic INV            = 1'b1,
    parameter int   DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
`ifdef INPUT_COND_REPEAT_EN
    ,
    parameter int   REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int   REPEAT_RATE    = DEF_REPEAT_RATE
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int              DB_W    = cnt_w(DEBOUNCE_TICKS);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DB_W-1:0]        db_cnt;
    logic                   accept;
    logic                   rep_fire;

    // The sync chain resets to the idle pin level.
    // This prevents a phantom press from appearing right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{INV}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s      = sync_q[SYNC_STAGES-1] ^ INV;
    assign accept = tick && (s != level) && (db_cnt == DB_LAST);

    // The counter counts consecutive ticks on which the input disagrees with
    // the accepted level.
    // Any agreeing tick restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (tick) begin
            if (s == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

`ifdef INPUT_COND_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = cnt_w(REP_MAX);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_armed;

    // The first repeat waits REPEAT_DELAY ticks after acceptance.
    // Once rep_armed is set, later repeats use REPEAT_RATE.
    // A release accepted on this tick takes priority over any repeat.
    assign rep_fire = tick && level && !accept &&
                      ((!rep_armed && (rep_cnt == REP_W'(REPEAT_DELAY - 1))) ||
                       ( rep_armed && (rep_cnt == REP_W'(REPEAT_RATE - 1))));

    always_ff @(posedge clk) begin
        if (rst || !level || accept) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (tick) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Pulses are registered, so they rise on the same edge as the level.
    // When accept is high, s holds the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= (accept && s) || rep_fire;
            release_pulse <= accept && !s;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// N-channel synchroniser, debouncer and edge detector for push-buttons and
// switches.
// Each channel is an independent input_cond_chan. INV_MASK marks the pins that
// are active-low.
// Optional feature: define INPUT_COND_REPEAT_EN to enable auto-repeat press
// pulses (REPEAT_DELAY / REPEAT_RATE).
// Ports:
//   clk           in  system clock
//   rst           in  synchronous reset, active-high
//   tick          in  debounce sample strobe, one clk wide
//   raw_in        in  [N_CH] asynchronous pins
//   level_out     out [N_CH] debounced levels, 1 = pressed
//   press_pulse   out [N_CH] one-clk press pulses
//   release_pulse out [N_CH] one-clk release pulses
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int              N_CH           = 4,
    parameter int              SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter logic [N_CH-1:0] INV_MASK       = '1,
    parameter int              DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
`ifdef INPUT_COND_REPEAT_EN
    ,
    parameter int              REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int              REPEAT_RATE    = DEF_REPEAT_RATE
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        input_cond_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .INV           (INV_MASK[i]),
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
`ifdef INPUT_COND_REPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_RATE   (REPEAT_RATE)
`endif
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .raw          (raw_in[i]),
            .level        (level_out[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner.
// Configuration: 4 active-low channels, 2 sync stages, 3 debounce ticks, and a
// tick every 4 clk.
// A reference model is evaluated at each posedge. It pushes the expected pulse
// events into a queue. A monitor on the negedge pops an entry whenever the DUT
// shows a pulse.
`timescale 1ns/1ps
module tb_input_conditioner;

    localparam int N_CH = 4;
    localparam int SYNC = 2;
    localparam logic [N_CH-1:0] INV = 4'b1111;
    localparam int DB = 3;
`ifdef INPUT_COND_REPEAT_EN
    localparam int RDLY  = 5;
    localparam int RRATE = 2;
`endif

    typedef logic [N_CH-1:0] ch_vec_t;
    typedef struct {
        int      cyc;
        ch_vec_t p;
        ch_vec_t r;
        ch_vec_t lvl;
    } ev_t;

    logic    clk;
    logic    rst;
    logic    tick;
    ch_vec_t raw_in;
    ch_vec_t level_out;
    ch_vec_t press_pulse;
    ch_vec_t release_pulse;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    bit      tick_hi = 0;
    ev_t     exp_q[$];
    ch_vec_t pin_hist[$];
    ch_vec_t m_lvl = '0;
    int      run[N_CH];
    int      held[N_CH];
    int      press_cnt[N_CH];

    input_conditioner #(
        .N_CH          (N_CH),
        .SYNC_STAGES   (SYNC),
        .INV_MASK      (INV),
        .DEBOUNCE_TICKS(DB)
`ifdef INPUT_COND_REPEAT_EN
        ,
        .REPEAT_DELAY  (RDLY),
        .REPEAT_RATE   (RRATE)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .raw_in       (raw_in),
        .level_out    (level_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The tick strobe is either one clk in every four or held high
    // continuously.
    initial begin
        int tc = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_hi) begin
                tick = 1'b1;
            end else begin
                tick = (tc == 3);
                tc = (tc + 1) % 4;
            end
        end
    end

    task automatic checkOutput(input string nm, input ch_vec_t act, input ch_vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input ch_vec_t v, input int n_clk);
        raw_in = v;
        repeat (n_clk) @(negedge clk);
    endtask

    // Reference model.
    // A pin value becomes visible SYNC clocks after it is sampled. A reset
    // makes the delayed view show the idle level.
    // A level is accepted on the DB-th consecutive tick that disagrees with
    // the current level.
    // With repeat enabled, a held press fires again at RDLY ticks after
    // acceptance, then every RRATE ticks.
    always @(posedge clk) begin
        ch_vec_t s;
        ch_vec_t ep;
        ch_vec_t er;
        ch_vec_t old_lvl;
        bit      chg;
        cyc++;
        if (rst) begin
            pin_hist.delete();
            for (int k = 0; k <= SYNC; k++) pin_hist.push_back(INV);
            m_lvl = '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                run[ch]  = 0;
                held[ch] = 0;
            end
        end else begin
            pin_hist.push_back(raw_in);
            if (pin_hist.size() > SYNC + 1) void'(pin_hist.pop_front());
            s = (pin_hist.size() > SYNC) ? (pin_hist[pin_hist.size() - 1 - SYNC] ^ INV) : '0;
            if (tick) begin
                ep = '0;
                er = '0;
                old_lvl = m_lvl;
                for (int ch = 0; ch < N_CH; ch++) begin
                    chg = 1'b0;
                    if (s[ch] != m_lvl[ch]) begin
                        run[ch]++;
                        if (run[ch] == DB) begin
                            m_lvl[ch] = s[ch];
                            run[ch]   = 0;
                            held[ch]  = 0;
                            chg       = 1'b1;
                            if (s[ch]) ep[ch] = 1'b1;
                            else       er[ch] = 1'b1;
                        end
                    end else begin
                        run[ch] = 0;
                    end
`ifdef INPUT_COND_REPEAT_EN
                    if (old_lvl[ch] && !chg) begin
                        held[ch]++;
                        if (held[ch] == RDLY ||
                            (held[ch] > RDLY && ((held[ch] - RDLY) % RRATE) == 0))
                            ep[ch] = 1'b1;
                    end
`else
                    if (old_lvl[ch] && !chg) held[ch]++;
`endif
                end
                if ((ep | er) != '0) exp_q.push_back('{cyc: cyc, p: ep, r: er, lvl: m_lvl});
            end
        end
    end

    // Scoreboard monitor.
    // An expected event left in the queue for an earlier cycle means the DUT
    // missed a pulse.
    always @(negedge clk) begin
        ev_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missed_pulse: got no pulse, expected press=%b release=%b at cycle %0d",
                     e.p, e.r, e.cyc);
        end
        if ((press_pulse | release_pulse) != '0) begin
            for (int ch = 0; ch < N_CH; ch++) if (press_pulse[ch]) press_cnt[ch]++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got press=%b release=%b, expected none (cycle %0d)",
                         press_pulse, release_pulse, cyc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("press_pulse", press_pulse, e.p);
                checkOutput("release_pulse", release_pulse, e.r);
                checkOutput("level_at_pulse", level_out, e.lvl);
            end
        end
    end

    task automatic clearCounts();
        for (int ch = 0; ch < N_CH; ch++) press_cnt[ch] = 0;
    endtask

    initial begin
        bit found;
        int seg;
        ch_vec_t v;
        rst = 1'b1;
        raw_in = '0;
        clearCounts();

        // Reset held for 3 clk with the pins driven active.
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_level", level_out, '0);
            checkOutput("reset_press", press_pulse, '0);
            checkOutput("reset_release", release_pulse, '0);
        end
        rst = 1'b0;
        applyStimulus(4'b1111, 20);
        checkOutput("idle_level", level_out, 4'b0000);

        // Clean press and release on channel 0.
        applyStimulus(4'b1110, 30);
        checkOutput("clean_press_level", level_out, 4'b0001);
        checkOutput("clean_press_count", ch_vec_t'(press_cnt[0]), 4'd1);
        applyStimulus(4'b1111, 30);
        checkOutput("clean_release_level", level_out, 4'b0000);

        // Bounce on channel 1: low for 2 ticks, high for 1, then steady low.
        clearCounts();
        applyStimulus(4'b1101, 8);
        applyStimulus(4'b1111, 4);
        checkOutput("bounce_no_early_press", ch_vec_t'(press_cnt[1]), 4'd0);
        applyStimulus(4'b1101, 24);
        checkOutput("bounce_single_press", ch_vec_t'(press_cnt[1]), 4'd1);
        checkOutput("bounce_level", level_out, 4'b0010);
        applyStimulus(4'b1111, 30);

        // Simultaneous press on channels 3 and 2.
        clearCounts();
        applyStimulus(4'b0011, 30);
        checkOutput("simul_level", level_out, 4'b1100);
        checkOutput("simul_quiet_ch01",
                    ch_vec_t'(press_cnt[0] + press_cnt[1]), 4'd0);

        // Reset while channel 0 is mid-debounce and channels 3:2 are held.
        raw_in = 4'b0010;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (run[0] == 2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL mid_debounce_wait: timed out, required run length 2");
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_level", level_out, 4'b0000);
        checkOutput("midrst_press", press_pulse, 4'b0000);
        rst = 1'b0;
        applyStimulus(4'b0010, 40);
        checkOutput("after_midrst_level", level_out, 4'b1101);
        applyStimulus(4'b1111, 40);
        checkOutput("all_released", level_out, 4'b0000);

        // Long hold on channel 0. This exercises auto-repeat when enabled.
        clearCounts();
        applyStimulus(4'b1110, 2 + 4 * DB + 4 * 12 + 2);
`ifdef INPUT_COND_REPEAT_EN
        checks++;
        if (press_cnt[0] < 5) begin
            errors++;
            $display("[TB] FAIL repeat_count: got %0d presses, required at least 5", press_cnt[0]);
        end
`else
        checkOutput("hold_single_press", ch_vec_t'(press_cnt[0]), 4'd1);
`endif
        applyStimulus(4'b1111, 40);
        checkOutput("hold_released", level_out, 4'b0000);

        // tick held continuously high with random pin activity.
        tick_hi = 1'b1;
        for (int k = 0; k < 60; k++) begin
            v = raw_in;
            if ($urandom_range(0, 3) == 0) v = v ^ ch_vec_t'($urandom_range(1, 15));
            applyStimulus(v, $urandom_range(1, 6));
        end
        tick_hi = 1'b0;
        applyStimulus(4'b1111, 20);
        checkOutput("tickhi_settle", level_out, m_lvl);

        // Random segments with bouncy edges and occasional resets.
        for (seg = 0; seg < 250; seg++) begin
            v = raw_in ^ ch_vec_t'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) applyStimulus(v ^ ch_vec_t'($urandom_range(0, 15)), $urandom_range(1, 4));
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end
            applyStimulus(v, $urandom_range(1, 24));
        end

        applyStimulus(4'b1111, 40);
        checkOutput("final_level", level_out, m_lvl);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_events: got %0d left in queue, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
